mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

- Shares one single-ported unified RAM between the instruction-fetch stage and the memory stage.
- Grants one requester at a time and drives the RAM request/acknowledge handshake.
- Returns read data with a one-cycle ready pulse and produces the freeze signals that stall the fetch and memory stages while they wait.
- Replaces direct combinational instruction-memory access when the pipeline moves to a shared multi-cycle memory.

## Interface
- STARVE_LIMIT, 4: consecutive memory grants allowed while fetch waits before fetch is forced to win. 0 = memory always has priority. Max 255.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- ifReq  in  1  fetch requests the instruction at ifAddress
- ifAddress  in  32  fetch byte address
- ifReady  out  1  one-cycle pulse: ifData valid
- ifData  out  32  registered instruction word
- memRead  in  1  memory-stage load request
- memWrite  in  1  memory-stage store request
- memAddress  in  32  load/store byte address
- memWriteData  in  32  store data
- memReady  out  1  one-cycle pulse: load or store complete
- memReadData  out  32  registered load data
- ramReq  out  1  RAM request, held until ramAck
- ramWe  out  1  RAM write enable, valid with ramReq
- ramAddress  out  32  RAM address, valid with ramReq
- ramWriteData  out  32  RAM write data, valid with ramReq
- ramAck  in  1  RAM completion, one cycle; read data valid the same cycle
- ramReadData  in  32  RAM read data
- freezeFetch  out  1  combinational: ifReq & ~ifReady
- freezeMem  out  1  combinational: (memRead | memWrite) & ~memReady

## Operation
- States: IDLE, IF_BUSY, MEM_BUSY, RESP.
- **IDLE, arbitration:**
  - memory request only → MEM_BUSY.
  - ifReq only → IF_BUSY.
  - Both requesting → MEM_BUSY, unless starveCnt == STARVE_LIMIT and STARVE_LIMIT != 0; then IF_BUSY.
  - Neither → stay in IDLE.
- **At grant:** ramAddress, ramWe and ramWriteData are registered from the granted requester, and ramReq is set.
  - Fetch grant: ramWe = 0.
  - memWrite=1 grant: ramWe = 1. memWrite takes precedence if memRead and memWrite are both high.
- **starveCnt (8-bit):**
  - +1 on each memory grant made while ifReq = 1.
  - Cleared on each fetch grant.
  - Saturates at 255.
- **IF_BUSY / MEM_BUSY:**
  - ram* outputs held stable until ramAck.
  - On ramAck: ramReq cleared; ramReadData captured into ifData (IF_BUSY) or memReadData (MEM_BUSY, reads only; memReadData unchanged for stores); go to RESP.
- **RESP:** lasts exactly one cycle.
  - Asserts ifReady or memReady, matching the completed transaction.
  - No grant is made in RESP; stale requests are not re-served.
  - → IDLE.
- **Request withdrawal:** a transaction in flight always completes and still gives its ready pulse; a flushed requester ignores it.
- ramAck outside IF_BUSY/MEM_BUSY is ignored.
- Addresses are passed through unmodified; alignment is the RAM's concern.

## Timing
- **Reset:**
  - State IDLE, starveCnt = 0.
  - ramReq, ramWe, ifReady, memReady = 0.
  - ramAddress, ramWriteData, ifData, memReadData = 0.
- **Reset mid-transaction:** the transaction is abandoned, ramReq = 0 the next cycle, and no ready pulse is given.
- **Minimum latency:**
  - Request seen in IDLE at cycle N → ramReq high at N+1.
  - ramAck at N+1 → ready high at N+2.
  - Next grant at N+3 at the earliest.
- **Throughput:** one transaction per 3 cycles, plus RAM wait cycles.
- **Stalls:** freezeFetch and freezeMem are combinational; they deassert in the ready cycle so the stage advances at that edge.
- No combinational path from ramAck to ram* outputs.
- ramReq never falls without a ramAck, except on reset.

## Test plan
- **Fetch only:** ifReq=1, ifAddress=0x100, RAM acks 1 cycle after ramReq with 0xE3A01005 → ramReq at N+1 with ramWe=0, ramAddress=0x100; ifReady pulse at N+2 with ifData=0xE3A01005; freezeFetch high N..N+1, low at N+2.
- **Contention:** ifReq and memRead both high, memAddress=0x400, STARVE_LIMIT=4 → memory served first; memReady pulse, then fetch granted the cycle after RESP; starveCnt 1 → 0.
- **Starvation:** memRead held high continuously with ifReq high → exactly 4 memory grants, then a fetch grant; the 5th memory grant follows that fetch.
- **Store with 3 wait cycles:** memWrite=1, memAddress=0x20, memWriteData=0xDEADBEEF, ramAck 3 cycles after ramReq → ramWe=1 and ram* values stable for 4 cycles; memReady one cycle; memReadData unchanged.
- **Reset mid-transaction:** rst pulsed while in IF_BUSY → ramReq=0 and all outputs at reset values the next cycle; no ifReady pulse; a late ramAck is ignored.
- **Withdrawal:** ifReq dropped after grant → transaction completes; ifReady still pulses once; no further grant while no request is pending.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbiter sharing one single-ported RAM between fetch and memory stages
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifReq,
    input  logic [31:0] ifAddress,
    output logic        ifReady,
    output logic [31:0] ifData,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] memAddress,
    input  logic [31:0] memWriteData,
    output logic        memReady,
    output logic [31:0] memReadData,
    output logic        ramReq,
    output logic        ramWe,
    output logic [31:0] ramAddress,
    output logic [31:0] ramWriteData,
    input  logic        ramAck,
    input  logic [31:0] ramReadData,
    output logic        freezeFetch,
    output logic        freezeMem
);

    typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, RESP} state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t      state_q;
    logic [7:0]  starve_q;
    logic        ram_req_q;
    logic        ram_we_q;
    logic [31:0] ram_addr_q;
    logic [31:0] ram_wdata_q;
    logic        if_ready_q;
    logic        mem_ready_q;
    logic [31:0] if_data_q;
    logic [31:0] mem_rdata_q;

    logic mem_req;
    logic force_if_d;
    logic grant_mem_d;
    logic grant_if_d;

    assign mem_req = memRead | memWrite;

    // Fetch wins a contended grant only once memory has had LIMIT grants in a row.
    always_comb begin
        force_if_d  = (LIMIT != 8'd0) && (starve_q == LIMIT);
        grant_mem_d = (state_q == IDLE) && mem_req && !(ifReq && force_if_d);
        grant_if_d  = (state_q == IDLE) && ifReq && !grant_mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= 8'd0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= 32'd0;
            ram_wdata_q <= 32'd0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else begin
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_mem_d) begin
                        state_q     <= MEM_BUSY;
                        ram_req_q   <= 1'b1;
                        ram_we_q    <= memWrite;
                        ram_addr_q  <= memAddress;
                        ram_wdata_q <= memWriteData;
                        if (ifReq && starve_q != 8'hFF) begin
                            starve_q <= starve_q + 8'd1;
                        end
                    end else if (grant_if_d) begin
                        state_q     <= IF_BUSY;
                        ram_req_q   <= 1'b1;
                        ram_we_q    <= 1'b0;
                        ram_addr_q  <= ifAddress;
                        ram_wdata_q <= 32'd0;
                        starve_q    <= 8'd0;
                    end
                end
                IF_BUSY: begin
                    if (ramAck) begin
                        state_q    <= RESP;
                        ram_req_q  <= 1'b0;
                        if_data_q  <= ramReadData;
                        if_ready_q <= 1'b1;
                    end
                end
                MEM_BUSY: begin
                    if (ramAck) begin
                        state_q     <= RESP;
                        ram_req_q   <= 1'b0;
                        mem_ready_q <= 1'b1;
                        if (!ram_we_q) begin
                            mem_rdata_q <= ramReadData;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ifReady      = if_ready_q;
    assign ifData       = if_data_q;
    assign memReady     = mem_ready_q;
    assign memReadData  = mem_rdata_q;
    assign ramReq       = ram_req_q;
    assign ramWe        = ram_we_q;
    assign ramAddress   = ram_addr_q;
    assign ramWriteData = ram_wdata_q;

    // Stall releases in the ready cycle so the stage advances on that edge.
    assign freezeFetch = ifReq & ~if_ready_q;
    assign freezeMem   = mem_req & ~mem_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifReq;
    logic [31:0] ifAddress;
    logic        ifReady;
    logic [31:0] ifData;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memReady;
    logic [31:0] memReadData;
    logic        ramReq;
    logic        ramWe;
    logic [31:0] ramAddress;
    logic [31:0] ramWriteData;
    logic        ramAck;
    logic [31:0] ramReadData;
    logic        freezeFetch;
    logic        freezeMem;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .ifReq(ifReq), .ifAddress(ifAddress), .ifReady(ifReady), .ifData(ifData),
        .memRead(memRead), .memWrite(memWrite), .memAddress(memAddress),
        .memWriteData(memWriteData), .memReady(memReady), .memReadData(memReadData),
        .ramReq(ramReq), .ramWe(ramWe), .ramAddress(ramAddress), .ramWriteData(ramWriteData),
        .ramAck(ramAck), .ramReadData(ramReadData),
        .freezeFetch(freezeFetch), .freezeMem(freezeMem)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; ifReq = 1'b0; ifAddress = '0; memRead = 1'b0; memWrite = 1'b0;
        memAddress = '0; memWriteData = '0; ramAck = 1'b0; ramReadData = '0;
        tick; tick;
        #1;
        chk("rst_ramReq", 32'(ramReq), 32'd0);
        chk("rst_ramWe", 32'(ramWe), 32'd0);
        chk("rst_ramAddress", ramAddress, 32'd0);
        chk("rst_ifReady", 32'(ifReady), 32'd0);
        chk("rst_memReady", 32'(memReady), 32'd0);
        chk("rst_ifData", ifData, 32'd0);
        chk("rst_memReadData", memReadData, 32'd0);
        rst = 1'b0;
        tick;

        // Fetch only, zero wait states
        ifReq = 1'b1; ifAddress = 32'h100; #1;
        chk("f_freeze_N", 32'(freezeFetch), 32'd1);
        chk("f_ramReq_N", 32'(ramReq), 32'd0);
        tick;
        chk("f_ramReq_N1", 32'(ramReq), 32'd1);
        chk("f_ramWe_N1", 32'(ramWe), 32'd0);
        chk("f_ramAddr_N1", ramAddress, 32'h100);
        chk("f_freeze_N1", 32'(freezeFetch), 32'd1);
        ramAck = 1'b1; ramReadData = 32'hE3A01005;
        tick;
        ramAck = 1'b0; #1;
        chk("f_ifReady_N2", 32'(ifReady), 32'd1);
        chk("f_ifData_N2", ifData, 32'hE3A01005);
        chk("f_freeze_N2", 32'(freezeFetch), 32'd0);
        chk("f_ramReq_N2", 32'(ramReq), 32'd0);
        ifReq = 1'b0;
        tick;
        chk("f_ifReady_N3", 32'(ifReady), 32'd0);
        chk("f_ramReq_N3", 32'(ramReq), 32'd0);
        tick;

        // Contention: memory first, then fetch once memory is satisfied
        ifReq = 1'b1; ifAddress = 32'h104; memRead = 1'b1; memAddress = 32'h400;
        tick;
        chk("c_ramAddr_mem", ramAddress, 32'h400);
        chk("c_ramWe_mem", 32'(ramWe), 32'd0);
        chk("c_starve_1", 32'(dut.starve_q), 32'd1);
        chk("c_freezeMem", 32'(freezeMem), 32'd1);
        ramAck = 1'b1; ramReadData = 32'h11112222;
        tick;
        ramAck = 1'b0; #1;
        chk("c_memReady", 32'(memReady), 32'd1);
        chk("c_memReadData", memReadData, 32'h11112222);
        chk("c_freezeMem_rdy", 32'(freezeMem), 32'd0);
        chk("c_ifReady_none", 32'(ifReady), 32'd0);
        memRead = 1'b0;
        tick;
        chk("c_idle_ramReq", 32'(ramReq), 32'd0);
        chk("c_idle_memReady", 32'(memReady), 32'd0);
        tick;
        chk("c_if_ramReq", 32'(ramReq), 32'd1);
        chk("c_if_ramAddr", ramAddress, 32'h104);
        chk("c_starve_0", 32'(dut.starve_q), 32'd0);
        ramAck = 1'b1; ramReadData = 32'hAAAA0001;
        tick;
        ramAck = 1'b0; ifReq = 1'b0; #1;
        chk("c_ifReady", 32'(ifReady), 32'd1);
        chk("c_ifData", ifData, 32'hAAAA0001);
        tick; tick;

        // Starvation: four memory grants, one fetch, then memory again
        ifReq = 1'b1; ifAddress = 32'h200; memRead = 1'b1; memAddress = 32'h300;
        for (int k = 0; k < 6; k++) begin
            int w;
            w = 0;
            while (!ramReq && w < 5) begin
                tick;
                w++;
            end
            chk("s_grant_seen", 32'(ramReq), 32'd1);
            chk($sformatf("s_grant%0d_addr", k), ramAddress, (k == 4) ? 32'h200 : 32'h300);
            ramAck = 1'b1; ramReadData = 32'h50000000 + 32'(k);
            tick;
            ramAck = 1'b0;
        end
        ifReq = 1'b0; memRead = 1'b0; #1;
        chk("s_last_memReadData", memReadData, 32'h50000005);
        chk("s_last_ifData", ifData, 32'h50000004);
        tick; tick;

        // Store with three RAM wait cycles
        memWrite = 1'b1; memAddress = 32'h20; memWriteData = 32'hDEADBEEF;
        tick;
        memAddress = 32'h24; memWriteData = 32'h0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("w_ramReq_c%0d", c), 32'(ramReq), 32'd1);
            chk($sformatf("w_ramWe_c%0d", c), 32'(ramWe), 32'd1);
            chk($sformatf("w_ramAddr_c%0d", c), ramAddress, 32'h20);
            chk($sformatf("w_ramWdata_c%0d", c), ramWriteData, 32'hDEADBEEF);
            chk($sformatf("w_freezeMem_c%0d", c), 32'(freezeMem), 32'd1);
            if (c == 3) begin
                ramAck = 1'b1; ramReadData = 32'h99999999;
            end
            tick;
        end
        ramAck = 1'b0; #1;
        chk("w_memReady", 32'(memReady), 32'd1);
        chk("w_memReadData_kept", memReadData, 32'h50000005);
        chk("w_ramReq_clr", 32'(ramReq), 32'd0);
        memWrite = 1'b0;
        tick;
        chk("w_memReady_pulse", 32'(memReady), 32'd0);
        tick;

        // Reset during a fetch transaction; a late ack must be ignored
        ifReq = 1'b1; ifAddress = 32'h500;
        tick;
        chk("r_ramReq_busy", 32'(ramReq), 32'd1);
        rst = 1'b1;
        tick;
        chk("r_ramReq", 32'(ramReq), 32'd0);
        chk("r_ramAddr", ramAddress, 32'd0);
        chk("r_ifData", ifData, 32'd0);
        chk("r_memReadData", memReadData, 32'd0);
        chk("r_ifReady", 32'(ifReady), 32'd0);
        rst = 1'b0; ifReq = 1'b0; ramAck = 1'b1; ramReadData = 32'h77777777;
        tick;
        ramAck = 1'b0; #1;
        chk("r_late_ifReady", 32'(ifReady), 32'd0);
        chk("r_late_ramReq", 32'(ramReq), 32'd0);
        chk("r_late_ifData", ifData, 32'd0);
        tick;

        // Withdrawal: fetch dropped after grant still completes once
        ifReq = 1'b1; ifAddress = 32'h600;
        tick;
        chk("x_ramReq", 32'(ramReq), 32'd1);
        ifReq = 1'b0;
        tick;
        chk("x_ramReq_held", 32'(ramReq), 32'd1);
        chk("x_ramAddr_held", ramAddress, 32'h600);
        chk("x_freezeFetch", 32'(freezeFetch), 32'd0);
        ramAck = 1'b1; ramReadData = 32'h00000066;
        tick;
        ramAck = 1'b0; #1;
        chk("x_ifReady", 32'(ifReady), 32'd1);
        chk("x_ifData", ifData, 32'h00000066);
        tick;
        chk("x_ifReady_once", 32'(ifReady), 32'd0);
        tick;
        chk("x_no_regrant", 32'(ramReq), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
